mem_responder: RTL

Handshaked data-memory responder for the RV32I core's load/store path: the memory-side end of the request/response interface the datapath drives with ALU address, store data and funct3 access mode. It accepts one request at a time, inserts a configurable number of wait states, performs byte/half/word little-endian access on internal storage, and returns a response held until consumed. It sits between the core's memory stage and the byte-addressed data RAM, and replaces the asynchronous data memory when a stallable bus is introduced.

---
 rtl/mem_responder.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// mem_responder: single-outstanding load/store responder over byte RAM; MEM_RESPONDER_ERR_EN enables alignment/mode errors.
// Latency: rsp_valid rises WAIT_CYCLES+1 cycles after the accept edge; one transaction per WAIT_CYCLES+3 cycles.
// Backpressure: req_ready low from accept until response handshake; response held indefinitely without rsp_ready.
module mem_responder #(
    parameter int ADDR_WIDTH  = 12,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_mode,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                  state, state_nxt;
    logic [3:0]              cnt;
    logic                    cap_we;
    logic [2:0]              cap_mode;
    logic [ADDR_WIDTH-1:0]   cap_addr;
    logic [31:0]             cap_wdata;
    logic                    accept, access;
    logic [7:0]              mem [2**ADDR_WIDTH];

    logic                    sz_half, sz_word, ld_unsigned, acc_err;
    logic [ADDR_WIDTH-1:0]   base, base1, base2, base3;
    logic [7:0]              b0, b1, b2, b3;
    logic [31:0]             ld_dat;

    // mode[1] set covers W and the illegal modes 011/110/111, which fall back to word access
    always_comb begin
        sz_half     = (cap_mode[1:0] == 2'b01);
        sz_word     = cap_mode[1];
        ld_unsigned = cap_mode[2];
        base        = cap_addr;
        if (sz_word)
            base[1:0] = 2'b00;
        else if (sz_half)
            base[0] = 1'b0;
    end

`ifdef MEM_RESPONDER_ERR_EN
    assign acc_err = (cap_mode == 3'b011) || (cap_mode[2:1] == 2'b11)
                   || (cap_we && cap_mode[2])
                   || (sz_half && cap_addr[0])
                   || (sz_word && (cap_addr[1:0] != 2'b00));
`else
    assign acc_err = 1'b0;
`endif

    assign base1 = base + ADDR_WIDTH'(1);
    assign base2 = base + ADDR_WIDTH'(2);
    assign base3 = base + ADDR_WIDTH'(3);
    assign b0    = mem[base];
    assign b1    = mem[base1];
    assign b2    = mem[base2];
    assign b3    = mem[base3];

    always_comb begin
        if (sz_word)
            ld_dat = {b3, b2, b1, b0};
        else if (sz_half)
            ld_dat = {{16{~ld_unsigned & b1[7]}}, b1, b0};
        else
            ld_dat = {{24{~ld_unsigned & b0[7]}}, b0};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        access    = 1'b0;
        case (state)
            IDLE: if (req_valid && req_ready) begin
                accept    = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: if (cnt == 4'd0) begin
                access    = 1'b1;
                state_nxt = RESP;
            end
            RESP: if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= 4'd0;
            cap_we    <= 1'b0;
            cap_mode  <= 3'd0;
            cap_addr  <= '0;
            cap_wdata <= 32'd0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            req_ready <= (state_nxt == IDLE);
            rsp_valid <= (state_nxt == RESP);
            if (accept) begin
                cap_we    <= req_we;
                cap_mode  <= req_mode;
                cap_addr  <= req_addr[ADDR_WIDTH-1:0];
                cap_wdata <= req_wdata;
                cnt       <= 4'(WAIT_CYCLES);
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (access) begin
                rsp_rdata <= (cap_we || acc_err) ? 32'd0 : ld_dat;
                rsp_err   <= acc_err;
            end else if (state == RESP && rsp_ready) begin
                rsp_rdata <= 32'd0;
                rsp_err   <= 1'b0;
            end
        end
    end

    // storage is deliberately not reset; a store lands on the edge entering RESP
    always_ff @(posedge clk) begin
        if (access && cap_we && !acc_err) begin
            mem[base] <= cap_wdata[7:0];
            if (sz_half || sz_word)
                mem[base1] <= cap_wdata[15:8];
            if (sz_word) begin
                mem[base2] <= cap_wdata[23:16];
                mem[base3] <= cap_wdata[31:24];
            end
        end
    end
endmodule
